// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the registered ALU-control sequencer: ALU codes, funct
// fields, ALUop classes, mul/div opcodes and the FSM state type.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_ADD  = 4'b1010;
  localparam logic [3:0] ALU_SUB  = 4'b1110;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  // Upper four funct bits shared by MULT/MULTU/DIV/DIVU (0110xx).
  localparam logic [3:0] F_MD_PREFIX = 4'b0110;

  localparam logic [1:0] AOP_RTYPE  = 2'b00;
  localparam logic [1:0] AOP_BRANCH = 2'b01;
  localparam logic [1:0] AOP_MEM    = 2'b10;
  localparam logic [1:0] AOP_IMM    = 2'b11;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Request/response bundle between ID stage, sequencer, EX stage and mul/div unit.
// out_illegal exists only when ALUCTL_ILLEGAL_TRAP_EN is defined.
interface alu_ctrl_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_ctrl;
  logic       out_md;
  logic       md_start;
  logic [1:0] md_op;
  logic       busy;
`ifdef ALUCTL_ILLEGAL_TRAP_EN
  logic       out_illegal;
`endif

  modport slave (
    input  in_valid, alu_op, funct, out_ready,
    output in_ready, out_valid, out_ctrl, out_md, md_start, md_op, busy
`ifdef ALUCTL_ILLEGAL_TRAP_EN
    , output out_illegal
`endif
  );

  modport master (
    output in_valid, alu_op, funct, out_ready,
    input  in_ready, out_valid, out_ctrl, out_md, md_start, md_op, busy
`ifdef ALUCTL_ILLEGAL_TRAP_EN
    , input out_illegal
`endif
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUop/funct decoder. With ALUCTL_ILLEGAL_TRAP_EN it also flags
// R-type functs outside the supported list.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] ctrl_o,
  output logic       is_md_o,
  output logic [1:0] md_op_o
`ifdef ALUCTL_ILLEGAL_TRAP_EN
  , output logic     illegal_o
`endif
);

  always_comb begin
    ctrl_o  = ALU_ADD;
    is_md_o = 1'b0;
    md_op_o = funct_i[1:0];
`ifdef ALUCTL_ILLEGAL_TRAP_EN
    illegal_o = 1'b0;
`endif
    case (alu_op_i)
      AOP_RTYPE: begin
        case (funct_i)
          F_ADD:   ctrl_o = ALU_ADD;
          F_SUB:   ctrl_o = ALU_SUB;
          F_AND:   ctrl_o = ALU_AND;
          F_OR:    ctrl_o = ALU_OR;
          F_XOR:   ctrl_o = ALU_XOR;
          F_NOR:   ctrl_o = ALU_NOR;
          F_SLT:   ctrl_o = ALU_SLT;
          F_SLTU:  ctrl_o = ALU_SLTU;
          F_SLL:   ctrl_o = ALU_SLL;
          F_SRL:   ctrl_o = ALU_SRL;
          default: begin
            // Unknown functs fall back to ADD so a stray encoding stays harmless.
            if (funct_i[5:2] == F_MD_PREFIX) is_md_o = 1'b1;
`ifdef ALUCTL_ILLEGAL_TRAP_EN
            else illegal_o = 1'b1;
`endif
          end
        endcase
      end
      AOP_BRANCH: ctrl_o = ALU_SUB;
      AOP_MEM:    ctrl_o = ALU_ADD;
      AOP_IMM: begin
        case (funct_i[1:0])
          2'b00:   ctrl_o = ALU_AND;
          2'b01:   ctrl_o = ALU_OR;
          2'b10:   ctrl_o = ALU_XOR;
          default: ctrl_o = ALU_SLT;
        endcase
      end
      default: ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU-control stage between ID and EX; sequences mul/div
// ops by stalling issue for MD_CYCLES. Optional macro: ALUCTL_ILLEGAL_TRAP_EN.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic          clk,
  input  logic          reset,
  alu_ctrl_seq_if.slave bus
);

  localparam int CNT_W = $clog2(MD_CYCLES + 1);

  logic [3:0] dec_ctrl;
  logic       dec_is_md;
  logic [1:0] dec_md_op;

  state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic       out_valid_q;
  logic [3:0] out_ctrl_q;
  logic       out_md_q;
  logic       md_start_q;
  logic [1:0] md_op_q;
  logic       busy_q;
  logic       accept;
  logic       drain;

`ifdef ALUCTL_ILLEGAL_TRAP_EN
  logic dec_illegal;
  logic illegal_q;
`endif

  alu_ctrl_decode u_decode (
    .alu_op_i (bus.alu_op),
    .funct_i  (bus.funct),
    .ctrl_o   (dec_ctrl),
    .is_md_o  (dec_is_md),
    .md_op_o  (dec_md_op)
`ifdef ALUCTL_ILLEGAL_TRAP_EN
    , .illegal_o (dec_illegal)
`endif
  );

  // Only issue while idle and the output register is free or draining this edge.
  assign bus.in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = out_valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_ctrl_q  <= 4'b0000;
      out_md_q    <= 1'b0;
      md_start_q  <= 1'b0;
      md_op_q     <= 2'b00;
      busy_q      <= 1'b0;
`ifdef ALUCTL_ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      md_start_q <= 1'b0;
      if (drain) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && dec_is_md) begin
            md_start_q <= 1'b1;
            md_op_q    <= dec_md_op;
            busy_q     <= 1'b1;
            cnt_q      <= CNT_W'(MD_CYCLES - 1);
            state_q    <= MD_BUSY;
          end else if (accept) begin
            out_valid_q <= 1'b1;
            out_ctrl_q  <= dec_ctrl;
            out_md_q    <= 1'b0;
`ifdef ALUCTL_ILLEGAL_TRAP_EN
            illegal_q   <= dec_illegal;
`endif
          end
        end
        MD_BUSY: begin
          // The output register was drained before issue, so completion never collides.
          if (cnt_q == '0) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            out_md_q    <= 1'b1;
            out_ctrl_q  <= ALU_ADD;
`ifdef ALUCTL_ILLEGAL_TRAP_EN
            illegal_q   <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ctrl  = out_ctrl_q;
  assign bus.out_md    = out_md_q;
  assign bus.md_start  = md_start_q;
  assign bus.md_op     = md_op_q;
  assign bus.busy      = busy_q;
`ifdef ALUCTL_ILLEGAL_TRAP_EN
  assign bus.out_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq with MD_CYCLES=4; covers ALUCTL_ILLEGAL_TRAP_EN when defined.
module tb_alu_ctrl_seq;
  import alu_ctrl_pkg::*;

  localparam int MDC = 4;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       md;
    logic       ill;
  } exp_t;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   cyc;
  exp_t sb[$];

  alu_ctrl_seq_if bus();

  alu_ctrl_seq #(.MD_CYCLES(MDC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every accepted output is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_out: out_valid=1 ctrl=%b md=%b with empty scoreboard", bus.out_ctrl, bus.out_md);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.out_ctrl !== e.ctrl || bus.out_md !== e.md) begin
          miscompares++;
          $display("[TB] FAIL sb_result: got ctrl=%b md=%b, want ctrl=%b md=%b", bus.out_ctrl, bus.out_md, e.ctrl, e.md);
        end
`ifdef ALUCTL_ILLEGAL_TRAP_EN
        vectors++;
        if (bus.out_illegal !== e.ill) begin
          miscompares++;
          $display("[TB] FAIL sb_illegal: got %b want %b (ctrl=%b)", bus.out_illegal, e.ill, e.ctrl);
        end
`endif
      end
    end
  end

  task automatic send(input logic [1:0] aop, input logic [5:0] fn, input logic [3:0] ectrl,
                      input logic emd, input logic eill, input bit track);
    bit ok;
    ok = 1'b0;
    bus.alu_op   = aop;
    bus.funct    = fn;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL accept_timeout: in_ready stayed low for aop=%b funct=%b", aop, fn);
    end else if (track) begin
      sb.push_back('{ectrl, emd, eill});
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d results outstanding, want 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.md_start !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: valid=%b busy=%b start=%b, want 000", bus.out_valid, bus.busy, bus.md_start);
    end
    vectors++;
    if (bus.out_ctrl !== 4'b0000 || bus.out_md !== 1'b0 || bus.md_op !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_regs: ctrl=%b md=%b md_op=%b, want 0000 0 00", bus.out_ctrl, bus.out_md, bus.md_op);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_stream();
    int c0;
    bus.out_ready = 1'b1;
    send(AOP_RTYPE, F_ADD, ALU_ADD, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_ctrl !== ALU_ADD || bus.out_md !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL add_latency: valid=%b ctrl=%b md=%b, want 1 1010 0", bus.out_valid, bus.out_ctrl, bus.out_md);
    end
    @(posedge clk);
    #1;
    c0 = cyc;
    send(AOP_RTYPE, F_XOR,  ALU_XOR,  1'b0, 1'b0, 1'b1);
    send(AOP_RTYPE, F_SLTU, ALU_SLTU, 1'b0, 1'b0, 1'b1);
    send(AOP_RTYPE, F_SRL,  ALU_SRL,  1'b0, 1'b0, 1'b1);
    send(AOP_RTYPE, F_SLL,  ALU_SLL,  1'b0, 1'b0, 1'b1);
    vectors++;
    if (cyc - c0 != 4) begin
      miscompares++;
      $display("[TB] FAIL stream_rate: 4 ops took %0d cycles, want 4", cyc - c0);
    end
    send(AOP_RTYPE, F_AND, ALU_AND, 1'b0, 1'b0, 1'b1);
    send(AOP_RTYPE, F_NOR, ALU_NOR, 1'b0, 1'b0, 1'b1);
    send(AOP_RTYPE, F_SLT, ALU_SLT, 1'b0, 1'b0, 1'b1);
    send(AOP_RTYPE, F_SUB, ALU_SUB, 1'b0, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    send(AOP_RTYPE, F_SUB, ALU_SUB, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_ctrl !== ALU_SUB || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL hold_%0d: valid=%b ctrl=%b in_ready=%b, want 1 1110 0", i, bus.out_valid, bus.out_ctrl, bus.in_ready);
      end
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(AOP_RTYPE, F_OR, ALU_OR, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_ctrl !== ALU_OR) begin
      miscompares++;
      $display("[TB] FAIL same_edge_load: valid=%b ctrl=%b, want 1 0001", bus.out_valid, bus.out_ctrl);
    end
    drain();
  endtask

  task automatic md_run(input logic [5:0] fn, input logic [1:0] eop);
    int busyCnt, startCnt, validAt;
    busyCnt = 0; startCnt = 0; validAt = 0;
    send(AOP_RTYPE, fn, ALU_ADD, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.md_start === 1'b1) startCnt++;
      if (bus.busy === 1'b1) begin
        busyCnt++;
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.md_op !== eop) begin
          miscompares++;
          $display("[TB] FAIL md_busy_%0d: in_ready=%b md_op=%b, want 0 %b", i, bus.in_ready, bus.md_op, eop);
        end
      end
      if (bus.out_valid === 1'b1) begin
        validAt = i;
        break;
      end
    end
    vectors++;
    if (busyCnt != MDC || startCnt != 1 || validAt != MDC + 1) begin
      miscompares++;
      $display("[TB] FAIL md_timing: busy=%0d start=%0d valid_at=%0d, want %0d 1 %0d", busyCnt, startCnt, validAt, MDC, MDC + 1);
    end
    vectors++;
    if (bus.out_md !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL md_done: out_md=%b busy=%b, want 1 0", bus.out_md, bus.busy);
    end
    drain();
  endtask

  task automatic test_muldiv();
    bus.out_ready = 1'b1;
    md_run(6'b011010, MD_DIV);
    md_run(6'b011001, MD_MULTU);
  endtask

  task automatic test_reset_abort();
    int seen;
    seen = 0;
    bus.out_ready = 1'b1;
    send(AOP_RTYPE, 6'b011000, ALU_ADD, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL abort_state: busy=%b valid=%b in_ready=%b, want 0 0 1", bus.busy, bus.out_valid, bus.in_ready);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("[TB] FAIL abort_ghost: out_valid seen %0d cycles after abort, want 0", seen);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_classes();
    logic ill;
`ifdef ALUCTL_ILLEGAL_TRAP_EN
    ill = 1'b1;
`else
    ill = 1'b0;
`endif
    bus.out_ready = 1'b1;
    send(AOP_BRANCH, 6'b000010, ALU_SUB, 1'b0, 1'b0, 1'b1);
    send(AOP_MEM,    6'b100010, ALU_ADD, 1'b0, 1'b0, 1'b1);
    send(AOP_IMM,    6'b110010, ALU_XOR, 1'b0, 1'b0, 1'b1);
    send(AOP_IMM,    6'b000000, ALU_AND, 1'b0, 1'b0, 1'b1);
    send(AOP_IMM,    6'b101101, ALU_OR,  1'b0, 1'b0, 1'b1);
    send(AOP_IMM,    6'b000011, ALU_SLT, 1'b0, 1'b0, 1'b1);
    send(AOP_BRANCH, 6'b011010, ALU_SUB, 1'b0, 1'b0, 1'b1);
    send(AOP_RTYPE,  6'b111111, ALU_ADD, 1'b0, ill,  1'b1);
    send(AOP_RTYPE,  F_ADD,     ALU_ADD, 1'b0, 1'b0, 1'b1);
    send(AOP_RTYPE,  6'b011100, ALU_ADD, 1'b0, ill,  1'b1);
    send(AOP_RTYPE,  F_SRL,     ALU_SRL, 1'b0, 1'b0, 1'b1);
    drain();
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    cyc           = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.alu_op    = 2'b00;
    bus.funct     = 6'b000000;
    bus.out_ready = 1'b0;
    test_reset();
    test_alu_stream();
    test_backpressure();
    test_muldiv();
    test_reset_abort();
    test_classes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
